// File: rtl/psram_arb_pkg.sv
// Shared types and helpers for the PSRAM command-port arbiter and its picker.
// State encoding is fixed so debug taps and future clients decode it the same way.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req scanning ptr, ptr+1, ... mod N.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         vld
);

    int p;

    // Scan from the farthest candidate down so the nearest one to ptr wins last.
    always_comb begin
        idx = '0;
        vld = |req;
        p   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            p = (int'(ptr) + k) % N;
            if (req[p[W-1:0]]) idx = p[W-1:0];
        end
    end

endmodule

// File: rtl/psram_rr_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller port; grant one cycle after request.
// Requesters wait (hold req) until granted; strobes route only to the registered winner.
module psram_rr_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        wr,
    input  logic [NPORTS-1:0]        rd,
    input  logic [NPORTS-1:0]        ub,
    input  logic [NPORTS-1:0]        lb,
    input  logic [NPORTS-1:0]        burst,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] data_wr,
    output logic [NPORTS-1:0]        grant,
    output logic [NPORTS-1:0]        port_data_ok,
    output logic [NPORTS-1:0]        port_op_begun,
    output logic [NPORTS-1:0]        port_op_finished,
    output logic                     timeout_err,
    input  logic                     op_begun,
    input  logic                     op_finished,
    input  logic                     data_ok,
    output logic [DATA_W-1:0]        app_data_out,
    output logic [ADDR_W-1:0]        app_addr,
    output logic                     app_wr,
    output logic                     app_rd,
    output logic                     app_ub,
    output logic                     app_lb,
    output logic                     app_burst
);

    localparam int WW = clog2(NPORTS);
    localparam int TW = clog2(TIMEOUT);
    localparam logic [WW-1:0] LAST  = WW'(NPORTS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [WW-1:0]     win_q, win_d;
    logic [WW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              terr_q, terr_d;
    logic [WW-1:0]     pick_idx;
    logic              pick_vld;

    rr_pick #(.N(NPORTS), .W(WW)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            win_q    <= '0;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        terr_d   = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = NPORTS'(1) << pick_idx;
                    win_d   = pick_idx;
                    timer_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                timer_d = timer_q + TW'(1);
                // op_begun outranks withdraw and timeout in the same cycle.
                if (op_begun) begin
                    if (op_finished) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else if (!req[win_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else if (timer_q == TLAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_BUSY: begin
                if (op_finished) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = (win_q == LAST) ? '0 : win_q + WW'(1);
                grant_d  = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AND-OR mux keyed on the registered one-hot grant; all zero when idle.
    always_comb begin
        app_data_out = '0;
        app_addr     = '0;
        app_wr       = 1'b0;
        app_rd       = 1'b0;
        app_ub       = 1'b0;
        app_lb       = 1'b0;
        app_burst    = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            app_data_out = app_data_out | ({DATA_W{grant_q[i]}} & data_wr[i*DATA_W +: DATA_W]);
            app_addr     = app_addr     | ({ADDR_W{grant_q[i]}} & addr[i*ADDR_W +: ADDR_W]);
            app_wr       = app_wr       | (grant_q[i] & wr[i]);
            app_rd       = app_rd       | (grant_q[i] & rd[i]);
            app_ub       = app_ub       | (grant_q[i] & ub[i]);
            app_lb       = app_lb       | (grant_q[i] & lb[i]);
            app_burst    = app_burst    | (grant_q[i] & burst[i]);
        end
    end

    assign grant            = grant_q;
    assign timeout_err      = terr_q;
    assign port_data_ok     = {NPORTS{data_ok}}     & grant_q;
    assign port_op_begun    = {NPORTS{op_begun}}    & grant_q;
    assign port_op_finished = {NPORTS{op_finished}} & grant_q;

endmodule

// File: tb/tb_psram_rr_arbiter.sv
// Directed bench for psram_rr_arbiter (TIMEOUT=8) with hand-computed expectations.
module tb_psram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    logic          clk, reset_n;
    logic [N-1:0]  req, wr, rd, ub, lb, burst;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data_wr;
    logic [N-1:0]  grant, port_data_ok, port_op_begun, port_op_finished;
    logic          timeout_err, op_begun, op_finished, data_ok;
    logic [DW-1:0] app_data_out;
    logic [AW-1:0] app_addr;
    logic          app_wr, app_rd, app_ub, app_lb, app_burst;

    int n_tests;
    int n_fail;

    psram_rr_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .rd(rd), .ub(ub), .lb(lb),
        .burst(burst), .addr(addr), .data_wr(data_wr), .grant(grant),
        .port_data_ok(port_data_ok), .port_op_begun(port_op_begun),
        .port_op_finished(port_op_finished), .timeout_err(timeout_err),
        .op_begun(op_begun), .op_finished(op_finished), .data_ok(data_ok),
        .app_data_out(app_data_out), .app_addr(app_addr), .app_wr(app_wr),
        .app_rd(app_rd), .app_ub(app_ub), .app_lb(app_lb), .app_burst(app_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while in GRANT; leaves the arbiter in RELEASE.
    task automatic run_op(input int busy);
        op_begun = 1'b1;
        step();
        op_begun = 1'b0;
        repeat (busy - 1) step();
        op_finished = 1'b1;
        step();
        op_finished = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'b1111;
        repeat (3) step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_tests++; if (app_addr !== 23'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", app_addr); end
        n_tests++; if ({app_wr, app_rd, app_ub, app_lb, app_burst} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl got %b want 00000", {app_wr, app_rd, app_ub, app_lb, app_burst}); end
        n_tests++; if (app_data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", app_data_out); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got %b want 0", timeout_err); end
        reset_n = 1'b1;
        req = 4'b0000;
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_grant got %b want 0000", grant); end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_g [5];
        logic [22:0] exp_a [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_a[0] = 23'h40000; exp_a[1] = 23'h41111; exp_a[2] = 23'h42222; exp_a[3] = 23'h43333; exp_a[4] = 23'h40000;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL fair_grant%0d got %b want %b", k, grant, exp_g[k]); end
            n_tests++; if (app_addr !== exp_a[k]) begin n_fail++; $display("FAIL fair_addr%0d got %h want %h", k, app_addr, exp_a[k]); end
            run_op(5);
            n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL fair_gap1_%0d got %b want 0000", k, grant); end
            step();
            n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL fair_gap2_%0d got %b want 0000", k, grant); end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_skip();
        req = 4'b0010;
        step();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL skip_p1 got %b want 0010", grant); end
        run_op(2);
        req = 4'b1010;
        step();
        step();
        n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL skip_p3_first got %b want 1000", grant); end
        run_op(2);
        step();
        step();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL skip_p1_after got %b want 0010", grant); end
        run_op(2);
        req = 4'b0000;
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", grant); end
        n_tests++; if (app_addr !== 23'h42222) begin n_fail++; $display("FAIL single_addr got %h want 42222", app_addr); end
        n_tests++; if (app_data_out !== 16'hA5A2) begin n_fail++; $display("FAIL single_data got %h want a5a2", app_data_out); end
        n_tests++; if ({app_wr, app_rd, app_ub, app_lb, app_burst} !== 5'b10010) begin
            n_fail++; $display("FAIL single_ctl got %b want 10010", {app_wr, app_rd, app_ub, app_lb, app_burst}); end
        op_begun = 1'b1;
        #1;
        n_tests++; if (port_op_begun !== 4'b0100) begin n_fail++; $display("FAIL single_begun got %b want 0100", port_op_begun); end
        step();
        op_begun = 1'b0;
        data_ok = 1'b1;
        #1;
        n_tests++; if (port_data_ok !== 4'b0100) begin n_fail++; $display("FAIL single_data_ok got %b want 0100", port_data_ok); end
        data_ok = 1'b0;
        step();
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_busy_grant got %b want 0100", grant); end
        op_finished = 1'b1;
        #1;
        n_tests++; if (port_op_finished !== 4'b0100) begin n_fail++; $display("FAIL single_finished got %b want 0100", port_op_finished); end
        step();
        op_finished = 1'b0;
        n_tests++; if (grant !== 4'b0000 || app_wr !== 1'b0) begin
            n_fail++; $display("FAIL single_release got grant %b wr %b want 0000 0", grant, app_wr); end
        req = 4'b0000;
        step();
        data_ok = 1'b1;
        #1;
        n_tests++; if (port_data_ok !== 4'b0000) begin n_fail++; $display("FAIL idle_strobe_drop got %b want 0000", port_data_ok); end
        data_ok = 1'b0;
        // Pointer should now be 3: scanning 3,0 picks port 0 over port 2.
        req = 4'b0101;
        step();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_ptr3 got %b want 0001", grant); end
        run_op(2);
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        step();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL to_grant got %b want 0001", grant); end
        repeat (7) step();
        n_tests++; if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL to_early got grant %b err %b want 0001 0", grant, timeout_err); end
        step();
        n_tests++; if (grant !== 4'b0000 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL to_fire got grant %b err %b want 0000 1", grant, timeout_err); end
        req = 4'b1001;
        step();
        step();
        n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL to_regrant_p3 got %b want 1000", grant); end
        run_op(2);
        step();
        step();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL to_regrant_p0 got %b want 0001", grant); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        req = 4'b0000;
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL withdraw got %b want 0000", grant); end
        step();
    endtask

    task automatic test_same_cycle();
        req = 4'b0100;
        step();
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL same_grant got %b want 0100", grant); end
        op_begun = 1'b1;
        op_finished = 1'b1;
        #1;
        n_tests++; if (port_op_finished !== 4'b0100 || port_op_begun !== 4'b0100) begin
            n_fail++; $display("FAIL same_strobes got fin %b beg %b want 0100 0100", port_op_finished, port_op_begun); end
        step();
        op_begun = 1'b0;
        op_finished = 1'b0;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL same_direct_release got %b want 0000", grant); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_busy();
        req = 4'b1000;
        step();
        n_tests++; if (grant !== 4'b1000 || app_rd !== 1'b1) begin
            n_fail++; $display("FAIL rb_grant got grant %b rd %b want 1000 1", grant, app_rd); end
        op_begun = 1'b1;
        step();
        op_begun = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (grant !== 4'b0000 || app_rd !== 1'b0) begin
            n_fail++; $display("FAIL rb_async got grant %b rd %b want 0000 0", grant, app_rd); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rb_terr got %b want 0", timeout_err); end
        req = 4'b1010;
        step();
        step();
        reset_n = 1'b1;
        step();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rb_after got %b want 0010", grant); end
        req = 4'b0000;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        req = '0; op_begun = 1'b0; op_finished = 1'b0; data_ok = 1'b0;
        wr = 4'b0101; rd = 4'b1010; ub = 4'b0011; lb = 4'b1100; burst = 4'b1001;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]    = 23'h40000 + 23'(i) * 23'h01111;
            data_wr[i*DW +: DW] = 16'hA5A0 + 16'(i);
        end
        test_reset();
        test_fairness();
        test_skip();
        test_single();
        test_timeout();
        test_same_cycle();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
